// File: rtl/qbus_slave_ctl.sv
// QBUS slave controller: sequences SYNC/DIN/DOUT/IAKO/RPLY, decodes the latched
// address to word RAM, IO page port or interrupt vector, and drives AD/RPLY.
// Optional build macro QBUS_SLV_HALT_REG_EN adds the halt/event register at 177710.
module qbus_slave_ctl #(
  parameter logic [15:0] RAM_TOP = 16'o100000,
  parameter logic [15:0] IO_BASE = 16'o160000,
  parameter int unsigned IO_TMO  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ad_n_i,
  output logic [15:0] ad_n_o,
  output logic        ad_oe,
  input  logic        sync_n,
  input  logic        din_n,
  input  logic        dout_n,
  input  logic        wtbt_n,
  input  logic        iako_n,
  output logic        rply_n,
  output logic [13:0] ram_addr,
  output logic        ram_re,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic [11:0] io_addr,
  output logic        io_rd,
  output logic        io_wr,
  output logic [1:0]  io_be,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  input  logic        io_ack,
  input  logic        irq_req,
  input  logic [7:0]  irq_vec,
  output logic        irq_ack,
  output logic        virq_n
`ifdef QBUS_SLV_HALT_REG_EN
  ,
  output logic        halt_n,
  output logic        evnt_n,
  output logic        halt_en
`endif
);

  localparam int unsigned TmoW = $clog2(IO_TMO) + 1;

  typedef enum logic [3:0] {
    StIdle, StAddr, StRdRam, StRdCap, StDrive, StWrRam, StRdIo, StWrIo, StVec, StReply, StWaitEnd
  } state_e;

  typedef enum logic [1:0] {SelNone, SelRam, SelIo, SelHalt} sel_e;

  state_e         state_q, state_d;
  logic [15:0]    addr_q, addr_d;
  logic           wflg_q, wflg_d;
  logic [1:0]     be_q, be_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [15:0]    ad_n_o_q, ad_n_o_d;
  logic           ad_oe_q, ad_oe_d;
  logic           rply_n_q, rply_n_d;
  logic           ram_re_q, ram_re_d;
  logic           ram_we_q, ram_we_d;
  logic           io_rd_q, io_rd_d;
  logic           io_wr_q, io_wr_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic           irq_ack_q, irq_ack_d;
  logic           virq_n_q;
  logic           sync_n_q;
  sel_e           sel;
  logic [15:0]    rd_word;
  logic           tmo_hit;

`ifdef QBUS_SLV_HALT_REG_EN
  localparam logic [15:0] HaltAddr = 16'o177710;
  logic halt_rq_q, evnt_rq_q, halt_en_q, halt_wr;
`endif

  // Address decode of the latched address; the halt register shadows its IO slot
  always_comb begin
    sel = SelNone;
    if (addr_q < RAM_TOP) sel = SelRam;
`ifdef QBUS_SLV_HALT_REG_EN
    else if (addr_q[15:1] == HaltAddr[15:1]) sel = SelHalt;
`endif
    else if (addr_q >= IO_BASE) sel = SelIo;
  end

`ifdef QBUS_SLV_HALT_REG_EN
  assign rd_word = (sel == SelHalt) ? {halt_en_q, 13'b0, evnt_rq_q, halt_rq_q} : ram_rdata;
`else
  assign rd_word = ram_rdata;
`endif

  assign tmo_hit = (tmo_q == TmoW'(IO_TMO - 1));

  // Bus handshake sequencer: next state and next registered outputs
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wflg_d    = wflg_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    ad_n_o_d  = ad_n_o_q;
    ad_oe_d   = ad_oe_q;
    rply_n_d  = rply_n_q;
    ram_re_d  = 1'b0;
    ram_we_d  = 1'b0;
    io_rd_d   = io_rd_q;
    io_wr_d   = io_wr_q;
    tmo_d     = tmo_q;
    irq_ack_d = 1'b0;
`ifdef QBUS_SLV_HALT_REG_EN
    halt_wr   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        // sync_n_q is cleared by reset so a cycle in flight is never picked up midway
        if (sync_n_q && !sync_n) begin
          addr_d  = ~ad_n_i;
          wflg_d  = ~wtbt_n;
          state_d = StAddr;
        end else if (!iako_n && !din_n && sync_n) begin
          state_d = StVec;
        end
      end
      StAddr: begin
        if (sync_n) begin
          state_d = StIdle;
        end else if (!din_n && !dout_n) begin
          state_d = StWaitEnd;
        end else if (!din_n) begin
          be_d = 2'b11;
          // DIN on a cycle flagged as write, or an unmapped address: let the CPU time out
          if (wflg_q || sel == SelNone) begin
            state_d = StWaitEnd;
          end else if (sel == SelIo) begin
            io_rd_d = 1'b1;
            tmo_d   = '0;
            state_d = StRdIo;
          end else begin
            ram_re_d = (sel == SelRam);
            state_d  = StRdRam;
          end
        end else if (!dout_n) begin
          be_d    = wtbt_n ? 2'b11 : (addr_q[0] ? 2'b10 : 2'b01);
          wdata_d = ~ad_n_i;
          if (sel == SelNone) begin
            state_d = StWaitEnd;
          end else if (sel == SelIo) begin
            io_wr_d = 1'b1;
            tmo_d   = '0;
            state_d = StWrIo;
          end else begin
            state_d = StWrRam;
          end
        end
      end
      StRdRam: state_d = StRdCap;
      StRdCap: begin
        ad_n_o_d = ~rd_word;
        ad_oe_d  = 1'b1;
        state_d  = StDrive;
      end
      // One clock of data setup on AD before RPLY
      StDrive: begin
        rply_n_d = 1'b0;
        state_d  = StReply;
      end
      StWrRam: begin
        ram_we_d = (sel == SelRam);
`ifdef QBUS_SLV_HALT_REG_EN
        halt_wr  = (sel == SelHalt);
`endif
        state_d  = StDrive;
      end
      StRdIo: begin
        if (io_ack) begin
          io_rd_d  = 1'b0;
          ad_n_o_d = ~io_rdata;
          ad_oe_d  = 1'b1;
          state_d  = StDrive;
        end else if (tmo_hit) begin
          io_rd_d  = 1'b0;
          state_d  = StWaitEnd;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWrIo: begin
        if (io_ack) begin
          io_wr_d  = 1'b0;
          rply_n_d = 1'b0;
          state_d  = StReply;
        end else if (tmo_hit) begin
          io_wr_d  = 1'b0;
          state_d  = StWaitEnd;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StVec: begin
        if (irq_req) begin
          ad_n_o_d  = ~{6'b0, irq_vec, 2'b00};
          ad_oe_d   = 1'b1;
          irq_ack_d = 1'b1;
          state_d   = StDrive;
        end else begin
          state_d = StWaitEnd;
        end
      end
      StReply: begin
        if (din_n && dout_n) begin
          rply_n_d = 1'b1;
          ad_oe_d  = 1'b0;
          ad_n_o_d = 16'hFFFF;
          // SYNC still low means a read-modify-write may follow with DOUT
          state_d  = sync_n ? StWaitEnd : StAddr;
        end
      end
      StWaitEnd: begin
        if (sync_n && din_n) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wflg_q    <= 1'b0;
      be_q      <= 2'b11;
      wdata_q   <= '0;
      ad_n_o_q  <= 16'hFFFF;
      ad_oe_q   <= 1'b0;
      rply_n_q  <= 1'b1;
      ram_re_q  <= 1'b0;
      ram_we_q  <= 1'b0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      tmo_q     <= '0;
      irq_ack_q <= 1'b0;
      virq_n_q  <= 1'b1;
      sync_n_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wflg_q    <= wflg_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      ad_n_o_q  <= ad_n_o_d;
      ad_oe_q   <= ad_oe_d;
      rply_n_q  <= rply_n_d;
      ram_re_q  <= ram_re_d;
      ram_we_q  <= ram_we_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
      tmo_q     <= tmo_d;
      irq_ack_q <= irq_ack_d;
      virq_n_q  <= ~irq_req;
      sync_n_q  <= sync_n;
    end
  end

`ifdef QBUS_SLV_HALT_REG_EN
  // Halt/event control register
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_rq_q <= 1'b0;
      evnt_rq_q <= 1'b0;
      halt_en_q <= 1'b0;
    end else if (halt_wr) begin
      halt_rq_q <= wdata_q[0];
      evnt_rq_q <= wdata_q[1];
      halt_en_q <= wdata_q[15];
    end
  end

  assign halt_n  = ~halt_rq_q;
  assign evnt_n  = ~evnt_rq_q;
  assign halt_en = halt_en_q;
`endif

  assign ad_n_o    = ad_n_o_q;
  assign ad_oe     = ad_oe_q;
  assign rply_n    = rply_n_q;
  assign ram_addr  = addr_q[14:1];
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign ram_be    = be_q;
  assign ram_wdata = wdata_q;
  assign io_addr   = addr_q[12:1];
  assign io_rd     = io_rd_q;
  assign io_wr     = io_wr_q;
  assign io_be     = be_q;
  assign io_wdata  = wdata_q;
  assign irq_ack   = irq_ack_q;
  assign virq_n    = virq_n_q;

endmodule

// File: tb/tb_qbus_slave_ctl.sv
// Scoreboard bench for qbus_slave_ctl: directed bus cycles push expected events,
// a monitor pops and compares whenever the DUT produces them.
module tb_qbus_slave_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ad_n_i, ad_n_o;
  logic        ad_oe, sync_n, din_n, dout_n, wtbt_n, iako_n, rply_n;
  logic [13:0] ram_addr;
  logic        ram_re, ram_we;
  logic [1:0]  ram_be, io_be;
  logic [15:0] ram_wdata, ram_rdata, io_wdata, io_rdata;
  logic [11:0] io_addr;
  logic        io_rd, io_wr, io_ack, irq_req, irq_ack, virq_n;
  logic [7:0]  irq_vec;
`ifdef QBUS_SLV_HALT_REG_EN
  logic        halt_n, evnt_n, halt_en;
`endif

  qbus_slave_ctl dut (
    .clk(clk), .rst(rst), .ad_n_i(ad_n_i), .ad_n_o(ad_n_o), .ad_oe(ad_oe),
    .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .iako_n(iako_n),
    .rply_n(rply_n), .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_be(ram_be), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_addr(io_addr),
    .io_rd(io_rd), .io_wr(io_wr), .io_be(io_be), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .io_ack(io_ack), .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack),
    .virq_n(virq_n)
`ifdef QBUS_SLV_HALT_REG_EN
    , .halt_n(halt_n), .evnt_n(evnt_n), .halt_en(halt_en)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic oe; logic [15:0] ad; int lat;} rply_t;
  typedef struct {logic [13:0] a; logic [1:0] be; logic [15:0] d;} we_t;
  typedef struct {logic [11:0] a; int len;} io_t;

  rply_t       exp_rply[$];
  int          exp_rel[$];
  logic [13:0] exp_re[$];
  we_t         exp_we[$];
  io_t         exp_io[$];
  logic [15:0] exp_irq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strb_cyc = 0;
  int rel_cyc = 0;
  int io_cnt = 0;
  logic io_en = 1'b0;
  logic [15:0] rd_val = '0;
  logic mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", nm);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data valid the clock after ram_re
  always @(posedge clk) if (ram_re) ram_rdata <= rd_val;

  // IO model: ack after io_rd has been high 5 clocks, when enabled
  always @(negedge clk) begin
    if (io_rd) io_cnt++;
    else io_cnt = 0;
    io_ack = io_en && io_rd && (io_cnt == 5);
  end

  // Monitor: pops the scoreboard whenever the DUT produces an event
  logic prev_rply = 1'b1, prev_io = 1'b0, prev_irq = 1'b0;
  int   io_len = 0, irq_len = 0;
  always @(posedge clk) begin
    rply_t r;
    we_t   w;
    io_t   o;
    int    e;
    logic [15:0] v;
    logic [13:0] a;
    #1;
    if (mon_en) begin
      if (prev_rply && !rply_n) begin
        if (exp_rply.size() == 0) unexp("rply_assert");
        else begin
          r = exp_rply.pop_front();
          chk("rply_oe", ad_oe, r.oe);
          chk("rply_ad", ad_n_o, r.ad);
          chk("rply_lat", cyc - strb_cyc - 1, r.lat);
        end
      end
      if (!prev_rply && rply_n) begin
        if (exp_rel.size() == 0) unexp("rply_release");
        else begin
          e = exp_rel.pop_front();
          chk("rel_lat", cyc - rel_cyc - 1, e);
          chk("rel_oe", ad_oe, 1'b0);
        end
      end
      if (ram_re) begin
        if (exp_re.size() == 0) unexp("ram_re");
        else begin
          a = exp_re.pop_front();
          chk("re_addr", ram_addr, a);
        end
      end
      if (ram_we) begin
        if (exp_we.size() == 0) unexp("ram_we");
        else begin
          w = exp_we.pop_front();
          chk("we_addr", ram_addr, w.a);
          chk("we_be", ram_be, w.be);
          chk("we_data", ram_wdata, w.d);
        end
      end
      if (io_wr) unexp("io_wr");
      if (io_rd) io_len++;
      else if (prev_io) begin
        if (exp_io.size() == 0) unexp("io_rd");
        else begin
          o = exp_io.pop_front();
          chk("io_addr", io_addr, o.a);
          chk("io_be", io_be, 2'b11);
          chk("io_rd_len", io_len, o.len);
        end
        io_len = 0;
      end
      if (irq_ack) begin
        irq_len++;
        if (!prev_irq) begin
          if (exp_irq.size() == 0) unexp("irq_ack");
          else begin
            v = exp_irq.pop_front();
            chk("irq_ad", ad_n_o, v);
            chk("irq_oe", ad_oe, 1'b1);
          end
        end
      end else if (prev_irq) begin
        chk("irq_width", irq_len, 1);
        irq_len = 0;
      end
    end
    prev_rply = rply_n;
    prev_io   = io_rd;
    prev_irq  = irq_ack;
  end

  task automatic addr_ph(input logic [15:0] a, input logic wr);
    @(negedge clk);
    ad_n_i = ~a;
    wtbt_n = ~wr;
    sync_n = 1'b0;
    @(negedge clk);
    ad_n_i = 16'hFFFF;
    wtbt_n = 1'b1;
  endtask

  task automatic wait_rply(input int n);
    for (int i = 0; i < n && rply_n; i++) @(negedge clk);
  endtask

  task automatic end_cyc();
    @(negedge clk);
    sync_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a);
    addr_ph(a, 1'b0);
    @(negedge clk);
    din_n = 1'b0;
    strb_cyc = cyc;
    wait_rply(30);
    @(negedge clk);
    din_n = 1'b1;
    rel_cyc = cyc;
    end_cyc();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic byt);
    addr_ph(a, 1'b1);
    @(negedge clk);
    ad_n_i = ~d;
    wtbt_n = ~byt;
    dout_n = 1'b0;
    strb_cyc = cyc;
    wait_rply(30);
    @(negedge clk);
    dout_n = 1'b1;
    ad_n_i = 16'hFFFF;
    wtbt_n = 1'b1;
    rel_cyc = cyc;
    end_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ad_n_i = 16'hFFFF; sync_n = 1'b1; din_n = 1'b1; dout_n = 1'b1;
    wtbt_n = 1'b1; iako_n = 1'b1; irq_req = 1'b0; irq_vec = 8'h00; io_rdata = 16'o000200;
    repeat (3) @(negedge clk);
    chk("rst_rply_n", rply_n, 1'b1);
    chk("rst_ad_oe", ad_oe, 1'b0);
    chk("rst_ad_n_o", ad_n_o, 16'hFFFF);
    chk("rst_strobes", {ram_re, ram_we, io_rd, io_wr, irq_ack}, 5'b0);
    chk("rst_virq_n", virq_n, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // 1: word read 001000 -> index 0x100, data 123456, reply 3 clks after DIN
    rd_val = 16'o123456;
    exp_re.push_back(14'h100);
    exp_rply.push_back('{1'b1, ~16'o123456, 3});
    exp_rel.push_back(0);
    rd(16'o001000);

    // 2: byte write to odd address 000003 -> index 1, high byte enable
    exp_we.push_back('{14'h001, 2'b10, 16'o177400});
    exp_rply.push_back('{1'b0, 16'hFFFF, 2});
    exp_rel.push_back(0);
    wr(16'o000003, 16'o177400, 1'b1);

    // 3: IO read 177564 with ack after 5 clks, then again with no ack (timeout at 16)
    io_en = 1'b1;
    exp_io.push_back('{12'hFBA, 5});
    exp_rply.push_back('{1'b1, ~16'o000200, 6});
    exp_rel.push_back(0);
    rd(16'o177564);
    io_en = 1'b0;
    exp_io.push_back('{12'hFBA, 16});
    rd(16'o177564);

    // 4: unmapped 140000 -> no reply at all
    rd(16'o140000);

    // 5: vectored interrupt 0x0D -> AD = 000064; then with no request, no reply
    irq_req = 1'b1;
    irq_vec = 8'h0D;
    repeat (2) @(negedge clk);
    chk("virq_n_req", virq_n, 1'b0);
    exp_irq.push_back(~16'o000064);
    exp_rply.push_back('{1'b1, ~16'o000064, 2});
    exp_rel.push_back(0);
    @(negedge clk);
    iako_n = 1'b0;
    din_n = 1'b0;
    strb_cyc = cyc;
    wait_rply(30);
    @(negedge clk);
    iako_n = 1'b1;
    din_n = 1'b1;
    rel_cyc = cyc;
    repeat (3) @(negedge clk);
    irq_req = 1'b0;
    @(negedge clk);
    iako_n = 1'b0;
    din_n = 1'b0;
    repeat (6) @(negedge clk);
    iako_n = 1'b1;
    din_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("virq_n_idle", virq_n, 1'b1);

    // 6: reset while replying; bus stays low across reset and must be ignored
    rd_val = 16'o052525;
    exp_re.push_back(14'h000);
    exp_rply.push_back('{1'b1, ~16'o052525, 3});
    exp_rel.push_back(0);
    addr_ph(16'o000000, 1'b0);
    @(negedge clk);
    din_n = 1'b0;
    strb_cyc = cyc;
    wait_rply(30);
    @(negedge clk);
    rst = 1'b1;
    rel_cyc = cyc;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ad_n_o", ad_n_o, 16'hFFFF);
    repeat (3) @(negedge clk);
    din_n = 1'b1;
    end_cyc();
    rd_val = 16'o007070;
    exp_re.push_back(14'h000);
    exp_rply.push_back('{1'b1, ~16'o007070, 3});
    exp_rel.push_back(0);
    rd(16'o000000);

    repeat (5) @(negedge clk);
    chk("left_rply", exp_rply.size(), 0);
    chk("left_rel", exp_rel.size(), 0);
    chk("left_re", exp_re.size(), 0);
    chk("left_we", exp_we.size(), 0);
    chk("left_io", exp_io.size(), 0);
    chk("left_irq", exp_irq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
